// File: rtl/instr_encoder.sv
// instr_encoder
//   Program loader: packs decoded RV32 fields back into 32-bit instruction
//   words and writes them to consecutive instruction-memory word addresses.
//   B and J immediates arrive in half-word units (byte offset >> 1), matching
//   the decoder's convention.
//
//   Optional feature macro: IMM_RANGE_CHECK_EN
//     defined   -> imm must sign-extend from its format width, else err
//     undefined -> upper imm bits beyond the format width are ignored
//
// Parameters
//   ADDR_W     instruction memory word-address width (DEPTH = 2**ADDR_W)
//   BASE_ADDR  first word address written after reset/start
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              synchronous clear of count/err/full, wins over in_valid
//   in_valid/in_ready  field-set handshake (in_ready = !full && !err && !start)
//   opcode..imm        decoded instruction fields
//   mem_we/addr/wdata  instruction memory write port, one cycle after transfer
//   count              instructions accepted since reset/start
//   full               count == DEPTH
//   err                sticky illegal-opcode / immediate-range fault
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [20:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_BAD
  } fmt_t;

  fmt_t        fmt;
  logic [31:0] enc;
  logic        range_ok;
  logic        xfer;
  logic        accept;
  logic        reject;

  // Classify the opcode into its encoding format; anything unknown
  // (including X) falls through to FMT_BAD and is rejected.
  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_R:                 fmt = FMT_R;
      OP_I, OP_L, OP_JALR:  fmt = FMT_I;
      OP_S:                 fmt = FMT_S;
      OP_B:                 fmt = FMT_B;
      OP_JAL:               fmt = FMT_J;
      default:              fmt = FMT_BAD;
    endcase
  end

  // Pack the fields. Each format only touches the fields it owns so that
  // don't-care inputs on the others never reach the memory word.
  always_comb begin
    enc = '0;
    case (fmt)
      FMT_R: enc = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: enc = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S: enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B: enc = {imm[11], imm[9:4], rs2, rs1, func3, imm[3:0], imm[10], opcode};
      FMT_J: enc = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
      default: enc = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // The supplied immediate must be a proper sign extension of the bits the
  // format can actually hold; R-type has no immediate to check.
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S, FMT_B: range_ok = (imm[20:11] == {10{imm[11]}});
      FMT_J:               range_ok = (imm[20] == imm[19]);
      default:             range_ok = 1'b1;
    endcase
  end
`else
  // Without the check imm[20] is never encoded anywhere.
  logic unused_imm;
  assign unused_imm = imm[20];
  assign range_ok   = 1'b1;
`endif

  assign full     = (count == DEPTH);
  assign in_ready = !full && !err && !start;
  assign xfer     = in_valid && in_ready;
  assign accept   = xfer && (fmt != FMT_BAD) && range_ok;
  assign reject   = xfer && !accept;

  // Write port is registered: a word accepted at one edge is presented for
  // exactly the following cycle. start only clears bookkeeping, so a write
  // already in flight completes at the address it was given.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= BASE + count[ADDR_W-1:0];
        mem_wdata <= enc;
      end
      if (start) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (accept) count <= count + (ADDR_W+1)'(1);
        if (reject) err   <= 1'b1;
      end
    end
  end

endmodule
